ln_iter: RTL and testbench

LN_ITER -- requirements
Module: ln_iter

---
 rtl/ln_iter.sv | 183 ++++++++++++++++++
 tb/tb_ln_iter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ln_iter.sv
// ln_iter: iterative fixed-point logarithm (natural or base-2).
// Finds the integer part of log2 from the operand MSB, then generates
// fraction bits by repeated squaring of the normalised mantissa, and
// optionally scales the base-2 result by a rounded ln(2) constant.
module ln_iter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ITERS = FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] F,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lnF,
    output logic             err
);

    // Mantissa carries one guard fraction bit beyond FRAC during squaring.
    localparam int MF = FRAC + 1;
    localparam int MW = MF + 1;
    // Integer part of log2 spans -FRAC .. WIDTH-1-FRAC; 8 signed bits cover it.
    localparam int KW = 8;
    localparam int CW = $clog2(FRAC + 1);
    localparam int PW = $clog2(WIDTH);
    // Base-2 result is kept wider than WIDTH so k*2^FRAC never wraps.
    localparam int LW = WIDTH + 8;
    // Full-precision width of the ln(2) scaling product.
    localparam int RW = LW + FRAC + 2;

    // ln(2) as a 64-bit binary fraction, rounded to FRAC bits below.
    localparam logic [64:0] LN2_Q64 = 65'h0B17217F7D1CF79AC;
    localparam logic [64:0] LN2_RND = LN2_Q64 + (65'd1 << (63 - FRAC));
    localparam logic [FRAC:0] LN2_Q = LN2_RND[64-FRAC +: FRAC+1];
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       f_q, f_d;
    logic                   mode_q, mode_d;
    logic signed [KW-1:0]   k_q, k_d;
    logic [MW-1:0]          m_q, m_d;
    logic [FRAC-1:0]        frac_q, frac_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       lnf_q, lnf_d;
    logic                   err_q, err_d;
    logic                   out_valid_q, out_valid_d;

    logic [PW-1:0]          msb_idx;
    logic [PW-1:0]          norm_shift;
    logic [MW-1:0]          m_norm;
    logic signed [KW-1:0]   k_norm;
    logic [MW:0]            sq_t;
    logic [MW-1:0]          m_iter;
    logic [FRAC-1:0]        frac_al;
    logic signed [LW-1:0]   l2;
    logic signed [FRAC+1:0] ln2_s;
    logic signed [RW-1:0]   prod;
    logic [RW-1:0]          prod_mag;
    logic [WIDTH-1:0]       ln_mag;
    logic [WIDTH-1:0]       ln_val;
    logic [WIDTH-1:0]       result;
    logic                   f_zero;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign lnF       = lnf_q;
    assign err       = err_q;

    // Priority search for the most significant set bit of the operand.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (f_q[i]) msb_idx = PW'(i);
        end
    end

    // Normalisation: shift MSB to the top, keep FRAC+1 significant bits.
    assign norm_shift = PW'(WIDTH - 1) - msb_idx;
    assign m_norm     = {(FRAC+1)'((f_q << norm_shift) >> (WIDTH - FRAC - 1)), 1'b0};
    assign k_norm     = KW'(msb_idx) - KW'(FRAC);
    assign f_zero     = (f_q == '0);

    // Squaring step: Q2.MF truncated square, halved when it reaches 2.
    assign sq_t   = (MW+1)'(((2*MW)'(m_q) * (2*MW)'(m_q)) >> MF);
    assign m_iter = sq_t[MW] ? sq_t[MW:1] : sq_t[MW-1:0];

    // Scaling: assemble log2 and multiply by ln(2), rounding half away from zero.
    assign frac_al  = frac_q << (FRAC - ITERS);
    assign l2       = {{(LW-FRAC-KW){k_q[KW-1]}}, k_q, frac_al};
    assign ln2_s    = {1'b0, LN2_Q};
    assign prod     = $signed(RW'(l2)) * $signed(RW'(ln2_s));
    assign prod_mag = prod[RW-1] ? RW'(-prod) : RW'(prod);
    assign ln_mag   = WIDTH'((prod_mag + (RW'(1) << (FRAC - 1))) >> FRAC);
    assign ln_val   = prod[RW-1] ? (WIDTH'(0) - ln_mag) : ln_mag;
    assign result   = f_zero ? MOST_NEG : (mode_q ? WIDTH'(l2) : ln_val);

    // Next-state logic of the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = NORM;
            NORM:    state_d = ITER;
            ITER:    if (cnt_q == CW'(ITERS - 1)) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates selected by the current state.
    always_comb begin
        f_d         = f_q;
        mode_d      = mode_q;
        k_d         = k_q;
        m_d         = m_q;
        frac_d      = frac_q;
        cnt_d       = cnt_q;
        lnf_d       = lnf_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f_d    = F;
                    mode_d = mode;
                end
            end
            NORM: begin
                k_d    = k_norm;
                m_d    = m_norm;
                frac_d = '0;
                cnt_d  = '0;
            end
            ITER: begin
                m_d    = m_iter;
                frac_d = {frac_q[FRAC-2:0], sq_t[MW]};
                cnt_d  = cnt_q + CW'(1);
            end
            SCALE: begin
                lnf_d = result;
                err_d = f_zero;
            end
            DONE: begin
                // Valid rises one cycle after DONE entry and drops on handshake.
                out_valid_d = !(out_valid_q && out_ready);
            end
            default: ;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            f_q         <= '0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            m_q         <= '0;
            frac_q      <= '0;
            cnt_q       <= '0;
            lnf_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            m_q         <= m_d;
            frac_q      <= frac_d;
            cnt_q       <= cnt_d;
            lnf_q       <= lnf_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ln_iter.sv
// tb_ln_iter: directed checks of ln_iter (default parameters) plus a
// reduced-width instance (WIDTH=24, FRAC=12, ITERS=8).
module tb_ln_iter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, mode, out_valid, out_ready, err;
    logic [31:0] F, lnF;

    logic        s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready, s_err;
    logic [23:0] s_F, s_lnF;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] r_lnf;
    logic        r_err;
    int          r_lat;

    ln_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (F),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lnF       (lnF),
        .err       (err)
    );

    ln_iter #(.WIDTH(24), .FRAC(12), .ITERS(8)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .F         (s_F),
        .mode      (s_mode),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .lnF       (s_lnF),
        .err       (s_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp, input int tol);
        logic signed [63:0] d;
        d = obs - exp;
        if (d < 0) d = -d;
        total++;
        assert ((d <= tol) === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (+/-%0d)", tag, obs, exp, tol);
        end
    endtask

    // Default instance: present one operand, wait for out_valid (bounded).
    task automatic do_op(input logic [31:0] f, input logic md, input string tag);
        int n;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        F = f; mode = md; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; F = ~f; mode = ~md;
        chk({tag, "_busy"}, 64'(in_ready), 64'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        r_lat = n; r_lnf = lnF; r_err = err;
        $display("op %s F=%h mode=%0d -> lnF=%h err=%0b latency=%0d", tag, f, md, r_lnf, r_err, r_lat);
        chk({tag, "_latency"}, 64'(r_lat), 64'd19);
    endtask

    // Accept the result; optionally offer a new operand in the same DONE cycle.
    task automatic release_out(input logic iv, input string tag);
        @(negedge clk);
        out_ready = 1'b1; in_valid = iv; F = 32'h0004_0000; mode = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Reduced-width instance: one full transaction including acceptance.
    task automatic s_op(input logic [23:0] f, input logic md, input logic [23:0] exp, input string tag);
        int n;
        @(negedge clk);
        s_F = f; s_mode = md; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0; s_F = ~f;
        n = 0;
        while (s_out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        $display("op %s F=%h mode=%0d -> lnF=%h err=%0b latency=%0d", tag, f, md, s_lnF, s_err, n);
        chk({tag, "_latency"}, 64'(n), 64'd11);
        chk({tag, "_lnF"}, 64'(s_lnF), 64'(exp));
        chk({tag, "_err"}, 64'(s_err), 64'd0);
        @(negedge clk); s_out_ready = 1'b1;
        @(posedge clk); #1; s_out_ready = 1'b0;
        chk({tag, "_rel"}, 64'(s_out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; F = '0; mode = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_F = '0; s_mode = 1'b0; s_out_ready = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_lnF", 64'(lnF), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;

        // ln(19.2426) ~ 2.9571, then back-pressure for 10 cycles.
        do_op(32'h0013_3E18, 1'b0, "ln_19p24");
        chk_near("ln_19p24_lnF", $signed(r_lnf), 64'sh2F508, 4);
        chk("ln_19p24_err", 64'(r_err), 64'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0]; F = $urandom; mode = c[1];
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_lnF", 64'(lnF), 64'(r_lnf));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        // in_valid offered in the DONE handshake cycle must not be taken.
        release_out(1'b1, "ln_19p24");

        do_op(32'h0008_0000, 1'b1, "log2_8");
        chk("log2_8_lnF", 64'(r_lnf), 64'h0003_0000);
        chk("log2_8_err", 64'(r_err), 64'd0);
        release_out(1'b0, "log2_8");

        do_op(32'h0001_0000, 1'b0, "ln_1");
        chk("ln_1_lnF", 64'(r_lnf), 64'h0);
        release_out(1'b0, "ln_1");

        do_op(32'h0001_0000, 1'b1, "log2_1");
        chk("log2_1_lnF", 64'(r_lnf), 64'h0);
        release_out(1'b0, "log2_1");

        do_op(32'h0000_0001, 1'b0, "ln_min");
        chk_near("ln_min_lnF", $signed(r_lnf), -64'sd726817, 4);
        chk("ln_min_sign", 64'(r_lnf[31]), 64'd1);
        release_out(1'b0, "ln_min");

        do_op(32'h0000_0000, 1'b0, "ln_zero");
        chk("ln_zero_err", 64'(r_err), 64'd1);
        chk("ln_zero_lnF", 64'(r_lnf), 64'h8000_0000);
        release_out(1'b0, "ln_zero");

        do_op(32'h0000_8000, 1'b1, "log2_half");
        chk("log2_half_lnF", 64'(r_lnf), 64'hFFFF_0000);
        chk("log2_half_err", 64'(r_err), 64'd0);
        release_out(1'b0, "log2_half");

        do_op(32'hFFFF_FFFF, 1'b1, "log2_max");
        chk_near("log2_max_lnF", $signed(r_lnf), 64'sh10_0000, 4);
        release_out(1'b0, "log2_max");

        // Abort in the 5th ITER cycle; lnF still holds the previous result.
        @(negedge clk);
        F = 32'h0003_0000; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        $display("op abort_reset in_ready=%0b out_valid=%0b lnF=%h err=%0b", in_ready, out_valid, lnF, err);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_lnF", 64'(lnF), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        do_op(32'h0002_0000, 1'b0, "ln_2_after_rst");
        chk_near("ln_2_lnF", $signed(r_lnf), 64'shB172, 4);
        chk("ln_2_err", 64'(r_err), 64'd0);
        release_out(1'b0, "ln_2_after_rst");

        // Reduced-width parameter set.
        s_op(24'h002000, 1'b1, 24'h001000, "s_log2_2");
        s_op(24'h001000, 1'b0, 24'h000000, "s_ln_1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
